// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline registers and the hazard controller.
// The pipeline side is the master: it supplies hazard fields and consumes the controls.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_id_instr;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             flush;
  logic             ex_mem_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_instr, id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
    input  pc_write, if_id_write, id_ex_bubble, flush, ex_mem_hold, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_instr, id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
    output pc_write, if_id_write, id_ex_bubble, flush, ex_mem_hold, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes,
// data-memory wait holds, plus saturating stall/flush perf counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic pc_write_c, if_id_write_c, bubble_c, flush_c, hold_c;
  logic load_use_c;
  logic [4:0] rs1, rs2;
  logic unused_instr_bits;

  assign rs1 = hz.if_id_instr[19:15];
  assign rs2 = hz.if_id_instr[24:20];
  assign unused_instr_bits = ^{hz.if_id_instr[31:25], hz.if_id_instr[14:0]};

  // Conservative: opcode is not decoded, so any field match stalls.
  assign load_use_c = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                      ((hz.id_ex_rd == rs1) || (hz.id_ex_rd == rs2));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_write_c    = 1'b0;
    if_id_write_c = 1'b0;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    hold_c        = 1'b0;
    unique case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (hz.mem_busy) begin
          hold_c  = 1'b1;
          state_d = S_MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          flush_c       = 1'b1;
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = S_RUN;
          end
        end else if (load_use_c) begin
          bubble_c = 1'b1;
          state_d  = S_RUN;
        end else begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          state_d       = S_RUN;
        end
      end
      S_FLUSH: begin
        // Slots being flushed carry no valid hazards; only a memory wait can pause the flush.
        if (hz.mem_busy) begin
          hold_c = 1'b1;
        end else begin
          flush_c       = 1'b1;
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          fcnt_d        = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Saturating perf counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is asserted.
  assign hz.pc_write     = rst_n & pc_write_c;
  assign hz.if_id_write  = rst_n & if_id_write_c;
  assign hz.id_ex_bubble = rst_n & bubble_c;
  assign hz.flush        = rst_n & flush_c;
  assign hz.ex_mem_hold  = rst_n & hold_c;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule
